mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-requester controller for the 8-entry x 8-bit `memory` block.
- Arbitrates round-robin between requester 0 (CPU datapath) and requester 1 (loader/debug port).
- Registers the winning command and sequences the memory's `enable`/`Write`/`Address`/`DataIn` pins.
- Captures `DataOut` and returns it to the winner with a one-cycle `done` pulse.
- Sits between the core's requesters and the single memory instance; it is the only driver of the memory control pins.

Parameters:
- ADDR_W, 3, memory address width.
- DATA_W, 8, memory data width.
- MAX_HOLD, 4, max consecutive locked grants to one requester (used only with MEM_ARB_LOCK_EN).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- r0_req  in  1  requester 0 access request; held high until r0_gnt.
- r0_write  in  1  1 = write, 0 = read.
- r0_addr  in  ADDR_W  access address.
- r0_wdata  in  DATA_W  write data.
- r0_gnt  out  1  one-cycle pulse; command accepted.
- r0_done  out  1  one-cycle pulse; access complete.
- r0_rdata  out  DATA_W  read data; valid when r0_done and the access was a read.
- r1_req, r1_write, r1_addr, r1_wdata, r1_gnt, r1_done, r1_rdata: same as requester 0.
- mem_enable  out  1  to memory `enable`.
- mem_write  out  1  to memory `Write`.
- mem_addr  out  ADDR_W  to memory `Address`.
- mem_wdata  out  DATA_W  to memory `DataIn`.
- mem_rdata  in  DATA_W  from memory `DataOut`; registered by the memory on the edge where enable=1 and Write=0.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; ports are named `clock` and `reset`.
- Reset values:
  - All outputs 0, including rdata registers.
  - State = IDLE.
  - last_gnt = 1, so r0 wins the first contention.
- FSM states: IDLE, ISSUE, CAPT.
- IDLE:
  - If any req is high, pick the winner. If both are high, the requester != last_gnt wins.
  - Latch the winner's write/addr/wdata into command registers; go to ISSUE.
  - No request: stay in IDLE; mem_enable = 0.
- ISSUE (exactly one cycle):
  - mem_enable = 1; mem_write/mem_addr/mem_wdata driven from the command registers.
  - Winner's gnt = 1 this cycle.
  - Go to CAPT.
- CAPT (exactly one cycle):
  - mem_enable = 0.
  - Read: winner's rdata <= mem_rdata. Write: rdata holds its previous value.
  - Winner's done = 1; last_gnt <= winner; go to IDLE.
- Latency and throughput:
  - Request sampled in IDLE at edge N.
  - gnt and mem_enable high in cycle N+1.
  - done high in cycle N+2; read data is valid in the same cycle as done.
  - One access per 3 cycles; the next arbitration is at edge N+3.
- Requester handshake:
  - Command must be stable from req rising until gnt; it may change after gnt.
  - req still high during the gnt cycle is ignored, because the FSM is not in IDLE.
  - The requester must drop req or present a new command after gnt. A req still high at the next IDLE is treated as a new request.
- A requester dropping req before gnt withdraws the request. This is legal only while the FSM is in IDLE.
- Outside ISSUE, mem_write/mem_addr/mem_wdata are 0.
- Never more than one gnt or done asserted in any cycle.
- Reset mid-operation (ISSUE or CAPT): the transaction is abandoned, no done is issued, and all outputs are 0 in the following cycle. A write already issued may have landed in memory.
- The address space is full-range (2^ADDR_W entries), so no address is out of range.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- Defined:
  - Adds inputs r0_lock and r1_lock.
  - If the winner's lock is high in its CAPT cycle, the next arbitration grants only that requester.
  - The lock lasts while its lock stays high, up to MAX_HOLD consecutive grants. A saturating hold counter resets when ownership changes.
  - When the count reaches MAX_HOLD and the other requester is waiting, the other requester is forced to win.
  - Ownership is released when lock drops.
- Undefined: lock ports and the hold counter do not exist; pure round-robin.

Decomposition:
- Package mem_arb_pkg:
  - FSM state enum (IDLE/ISSUE/CAPT).
  - Default ADDR_W/DATA_W.
  - Requester id constants REQ0=0, REQ1=1.
- Sub-module rr_arb2: 2-way round-robin pick from {req1, req0}, last_gnt and (when MEM_ARB_LOCK_EN is defined) lock/hold inputs. Outputs a one-hot winner.

Test Plan:
- Reset, then r0 writes addr 0 = 8'h08 → r0_gnt at cycle 1 with mem_enable=1, mem_write=1, mem_addr=0, mem_wdata=8'h08; r0_done at cycle 2; r1 outputs stay 0.
- r0 reads addr 0 after the write → r0_done with r0_rdata=8'h08 two cycles after sampling.
- r0 and r1 request together continuously (r0 write addr 3 = 8'hA5, r1 read addr 3) → grants alternate r0, r1, r0…; the first r1 read returns 8'hA5; gnts are spaced 3 cycles apart.
- Assert reset during ISSUE of an r1 read → no r1_done; all outputs 0 on the next cycle; the following request re-arbitrates with r0 favoured.
- Write addr 7 = 8'hFF, then read addr 7 → rdata 8'hFF. Write done leaves the previous rdata unchanged.
- MEM_ARB_LOCK_EN defined, MAX_HOLD=4, r0_lock=1, both requesting → four consecutive r0 grants, then a forced r1 grant. Dropping r0_lock after two grants → r1 is granted next.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-requester memory arbiter
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DATA_W = 8;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - 2-way round-robin winner pick; MEM_ARB_LOCK_EN adds lock/hold ownership
module rr_arb2
    import mem_arb_pkg::*;
`ifdef MEM_ARB_LOCK_EN
#(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 3
)
`endif
(
    input  logic [1:0]        req,
    input  logic              last_gnt,
`ifdef MEM_ARB_LOCK_EN
    input  logic [1:0]        lock,
    input  logic              locked,
    input  logic [HOLD_W-1:0] hold_cnt,
`endif
    output logic [1:0]        win
);

    always_comb begin
        win = req;
        if (req == 2'b11) begin
            win = (last_gnt == REQ1) ? 2'b01 : 2'b10;
        end
`ifdef MEM_ARB_LOCK_EN
        // A live lock pins the grant to the owner until the hold budget runs out
        if (locked && lock[last_gnt]) begin
            if (hold_cnt >= HOLD_W'(MAX_HOLD) && req[~last_gnt]) begin
                win = 2'b01 << ~last_gnt;
            end else begin
                win = req[last_gnt] ? (2'b01 << last_gnt) : 2'b00;
            end
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sequencing one 8x8 memory for two requesters (option: MEM_ARB_LOCK_EN)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
`ifdef MEM_ARB_LOCK_EN
    ,
    parameter int MAX_HOLD = 4
`endif
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_done,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_done,
    output logic [DATA_W-1:0] r1_rdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic              r0_lock,
    input  logic              r1_lock,
`endif
    output logic              mem_enable,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              win_id_q, win_id_d;
    logic              cmd_write_q, cmd_write_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic              mem_enable_q, mem_enable_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [1:0]        win;

`ifdef MEM_ARB_LOCK_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic              locked_q, locked_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    rr_arb2 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) u_arb (
        .req      ({r1_req, r0_req}),
        .last_gnt (last_gnt_q),
        .lock     ({r1_lock, r0_lock}),
        .locked   (locked_q),
        .hold_cnt (hold_q),
        .win      (win)
    );
`else
    rr_arb2 u_arb (
        .req      ({r1_req, r0_req}),
        .last_gnt (last_gnt_q),
        .win      (win)
    );
`endif

    always_comb begin
        state_d      = state_q;
        last_gnt_d   = last_gnt_q;
        win_id_d     = win_id_q;
        cmd_write_d  = cmd_write_q;
        gnt_d        = 2'b00;
        done_d       = 2'b00;
        mem_enable_d = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
`ifdef MEM_ARB_LOCK_EN
        locked_d     = locked_q;
        hold_d       = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (win != 2'b00) begin
                    win_id_d     = win[1];
                    cmd_write_d  = win[1] ? r1_write : r0_write;
                    gnt_d        = win;
                    mem_enable_d = 1'b1;
                    mem_write_d  = win[1] ? r1_write : r0_write;
                    mem_addr_d   = win[1] ? r1_addr  : r0_addr;
                    mem_wdata_d  = win[1] ? r1_wdata : r0_wdata;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                done_d  = (win_id_q == REQ1) ? 2'b10 : 2'b01;
                state_d = CAPT;
            end
            CAPT: begin
                last_gnt_d = win_id_q;
                if (!cmd_write_q) begin
                    if (win_id_q == REQ0) rdata0_d = mem_rdata;
                    else                  rdata1_d = mem_rdata;
                end
`ifdef MEM_ARB_LOCK_EN
                locked_d = win_id_q ? r1_lock : r0_lock;
                if (locked_q && win_id_q == last_gnt_q) begin
                    hold_d = (hold_q == HOLD_W'(MAX_HOLD)) ? hold_q : hold_q + HOLD_W'(1);
                end else begin
                    hold_d = HOLD_W'(1);
                end
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_gnt_q   <= REQ1;
            win_id_q     <= REQ0;
            cmd_write_q  <= 1'b0;
            gnt_q        <= 2'b00;
            done_q       <= 2'b00;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
`ifdef MEM_ARB_LOCK_EN
            locked_q     <= 1'b0;
            hold_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_gnt_q   <= last_gnt_d;
            win_id_q     <= win_id_d;
            cmd_write_q  <= cmd_write_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
`ifdef MEM_ARB_LOCK_EN
            locked_q     <= locked_d;
            hold_q       <= hold_d;
`endif
        end
    end

    // Memory data lands on the ISSUE->CAPT edge, so the done cycle forwards it directly
    assign r0_rdata   = (done_q[0] && !cmd_write_q) ? mem_rdata : rdata0_q;
    assign r1_rdata   = (done_q[1] && !cmd_write_q) ? mem_rdata : rdata1_q;
    assign r0_gnt     = gnt_q[0];
    assign r1_gnt     = gnt_q[1];
    assign r0_done    = done_q[0];
    assign r1_done    = done_q[1];
    assign mem_enable = mem_enable_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
